// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: R-type funct
// codes, the sequencing state encoding and the divide-by-zero LO value.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [31:0] DIV0_LO_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Single-step magnitude datapath. The 2*WIDTH accumulator holds
// {partial product, remaining multiplier} for multiply and
// {partial remainder, dividend/quotient bits} for divide; the operand
// register holds the multiplicand or divisor.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_op_is_div,
    input  logic [2*WIDTH-1:0] i_acc_init,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;

    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_divTrial;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_accNext;

    // One iteration: shift-add for multiply, restoring trial subtract for divide.
    always_comb begin
        w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
        w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};
        w_divTrial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_operand};
        if (w_divTrial[WIDTH]) begin
            w_divNext = {r_acc[2*WIDTH-2:0], 1'b0};
        end else begin
            w_divNext = {w_divTrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
        w_accNext = i_op_is_div ? w_divNext : w_mulNext;
    end

    // Working registers: loaded on accept, advanced once per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_operand <= '0;
        end else if (i_load) begin
            r_acc     <= i_acc_init;
            r_operand <= i_operand;
        end else if (i_step) begin
            r_acc     <= w_accNext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit. Decodes the muldiv funct codes, sequences
// a WIDTH-step iterative operation on magnitudes, applies the sign fix in a
// final cycle and owns the HI/LO registers and the mfhi/mflo read mux.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = WIDTH'(DIV0_LO_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t r_state;
    state_t w_stateNext;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_opIsDiv;
    logic             r_negA;
    logic             r_negB;
    logic             r_divZero;
    logic [WIDTH-1:0] r_in1;

    logic             w_busy;
    logic             w_isMulDiv;
    logic             w_accept;
    logic             w_idleWrite;
    logic             w_opIsDiv;
    logic             w_signed;
    logic             w_negA;
    logic             w_negB;
    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;
    logic [2*WIDTH-1:0] w_accInit;
    logic [WIDTH-1:0]   w_operand;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    assign w_busy      = (r_state != S_IDLE);
    assign w_idleWrite = valid && !w_busy;
    assign w_isMulDiv  = (funct == F_MULT) || (funct == F_MULTU) ||
                         (funct == F_DIV)  || (funct == F_DIVU);
    assign w_accept    = w_idleWrite && w_isMulDiv;

    // Operand decode: funct bit 1 selects divide, bit 0 clear means signed.
    always_comb begin
        w_opIsDiv = funct[1];
        w_signed  = !funct[0];
        w_negA    = w_signed && In1[WIDTH-1];
        w_negB    = w_signed && In2[WIDTH-1];
        w_magA    = w_negA ? -In1 : In1;
        w_magB    = w_negB ? -In2 : In2;
        if (w_opIsDiv) begin
            w_accInit = {{WIDTH{1'b0}}, w_magA};
            w_operand = w_magB;
        end else begin
            w_accInit = {{WIDTH{1'b0}}, w_magB};
            w_operand = w_magA;
        end
    end

    muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_step     (r_state == S_RUN),
        .i_op_is_div(r_opIsDiv),
        .i_acc_init (w_accInit),
        .i_operand  (w_operand),
        .o_acc      (w_acc)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state: IDLE waits for an accept, RUN counts WIDTH steps, FIX lasts one cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_stateNext = S_RUN;
            S_RUN:   if (r_count == LAST_STEP) w_stateNext = S_FIX;
            S_FIX:   w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Step counter and the operation attributes captured at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_opIsDiv <= 1'b0;
            r_negA    <= 1'b0;
            r_negB    <= 1'b0;
            r_divZero <= 1'b0;
            r_in1     <= '0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_opIsDiv <= w_opIsDiv;
            r_negA    <= w_negA;
            r_negB    <= w_negB;
            r_divZero <= (In2 == '0);
            r_in1     <= In1;
        end else if (r_state == S_RUN) begin
            r_count   <= r_count + 1'b1;
        end
    end

    // Sign correction of the magnitude result, plus the divide-by-zero override.
    always_comb begin
        w_product = (r_negA ^ r_negB) ? -w_acc : w_acc;
        w_quot    = (r_negA ^ r_negB) ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
        w_rem     = r_negA ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
        if (!r_opIsDiv) begin
            w_fixHi = w_product[2*WIDTH-1:WIDTH];
            w_fixLo = w_product[WIDTH-1:0];
        end else if (r_divZero) begin
            w_fixHi = r_in1;
            w_fixLo = DIV0_LO;
        end else begin
            w_fixHi = w_rem;
            w_fixLo = w_quot;
        end
    end

    // HI/LO registers: the FIX result, or mthi/mtlo when the unit is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                r_hi <= w_fixHi;
                r_lo <= w_fixLo;
            end else if (w_idleWrite && funct == F_MTHI) begin
                r_hi <= In1;
            end else if (w_idleWrite && funct == F_MTLO) begin
                r_lo <= In1;
            end
        end
    end

    // Move-from read mux into the EX result path.
    always_comb begin
        mf_result = '0;
        if (funct == F_MFHI) begin
            mf_result = r_hi;
        end else if (funct == F_MFLO) begin
            mf_result = r_lo;
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = w_busy;
    assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// corner sequences and randomized operations against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [5:0]  funct;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mfResult;
    logic        busy;
    logic        done;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[10];

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .funct    (funct),
        .In1      (In1),
        .In2      (In2),
        .hi       (hi),
        .lo       (lo),
        .mf_result(mfResult),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Plain-arithmetic reference for the four HI/LO-producing operations.
    function automatic void refModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] eh, output logic [31:0] el);
        longint          sa;
        longint          sb;
        longint          sq;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        eh = 32'h0;
        el = 32'h0;
        case (f)
            F_MULT: begin
                sq = sa * sb;
                eh = sq[63:32];
                el = sq[31:0];
            end
            F_MULTU: begin
                up = ua * ub;
                eh = up[63:32];
                el = up[31:0];
            end
            F_DIV, F_DIVU: begin
                if (b == 32'h0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else if (f == F_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    eh = sr[31:0];
                    el = sq[31:0];
                end else begin
                    up = ua / ub;
                    eh = 32'((ua % ub));
                    el = up[31:0];
                end
            end
            default: begin
                eh = 32'h0;
                el = 32'h0;
            end
        endcase
    endfunction

    // Issue one muldiv op, wait out busy, and check latency, done and HI/LO.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, input logic [31:0] eh, input logic [31:0] el);
        int n;
        valid = 1'b1;
        funct = f;
        In1   = a;
        In2   = b;
        tick();
        valid = 1'b0;
        funct = 6'h00;
        In1   = 32'h0;
        In2   = 32'h0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        checkOutput({tag, " busy cycles"}, n, 33);
        checkOutput({tag, " done"}, {31'b0, done}, 32'h1);
        checkOutput({tag, " hi"}, hi, eh);
        checkOutput({tag, " lo"}, lo, el);
    endtask

    initial begin
        int n;
        int doneSeen;
        logic [5:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;

        vecs[0] = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{F_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[5] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9] = '{F_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

        rst   = 1'b1;
        valid = 1'b0;
        funct = 6'h00;
        In1   = 32'h0;
        In2   = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset done", {31'b0, done}, 32'h0);

        // Back-to-back table: each op is accepted in the previous op's done cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].funct, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i),
                          vecs[i].expHi, vecs[i].expLo);
        end

        // multu then mflo/mfhi read-back; done must be a single-cycle pulse.
        applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 32'hFFFF_FFFE, 32'h0000_0001);
        valid = 1'b1;
        funct = F_MFLO;
        #1;
        checkOutput("mflo result", mfResult, 32'h0000_0001);
        funct = F_MFHI;
        #1;
        checkOutput("mfhi result", mfResult, 32'hFFFF_FFFE);
        funct = 6'h00;
        #1;
        checkOutput("mf_result other funct", mfResult, 32'h0);
        valid = 1'b0;
        tick();
        checkOutput("done pulse width", {31'b0, done}, 32'h0);
        checkOutput("hi holds", hi, 32'hFFFF_FFFE);

        // mthi / mtlo while idle take effect at the next edge.
        valid = 1'b1;
        funct = F_MTHI;
        In1   = 32'h0000_1234;
        tick();
        valid = 1'b0;
        funct = 6'h00;
        checkOutput("mthi idle hi", hi, 32'h0000_1234);
        checkOutput("mthi idle lo", lo, 32'h0000_0001);
        valid = 1'b1;
        funct = F_MTLO;
        In1   = 32'hCAFE_0042;
        tick();
        valid = 1'b0;
        funct = 6'h00;
        checkOutput("mtlo idle lo", lo, 32'hCAFE_0042);

        // mthi held during a busy mult is ignored; the mult result lands.
        valid = 1'b1;
        funct = F_MULT;
        In1   = 32'd3;
        In2   = 32'd5;
        tick();
        funct = F_MTHI;
        In1   = 32'h0000_1234;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        valid = 1'b0;
        funct = 6'h00;
        checkOutput("mthi busy latency", n, 33);
        checkOutput("mthi busy hi", hi, 32'h0);
        checkOutput("mthi busy lo", lo, 32'd15);
        tick();
        checkOutput("mthi busy not applied late", hi, 32'h0);

        // Reset in the middle of RUN discards the sequence.
        valid = 1'b1;
        funct = F_MULT;
        In1   = 32'd7;
        In2   = 32'd9;
        tick();
        valid = 1'b0;
        funct = 6'h00;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid-run reset busy", {31'b0, busy}, 32'h0);
        checkOutput("mid-run reset hi", hi, 32'h0);
        checkOutput("mid-run reset lo", lo, 32'h0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) doneSeen++;
            tick();
        end
        checkOutput("no done after reset", doneSeen, 0);
        applyStimulus(F_MULT, 32'd7, 32'd9, "mult after reset", 32'h0, 32'd63);

        // Randomized operations with occasional boundary operands.
        for (int i = 0; i < 30; i++) begin
            rf = F_MULT + 6'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h0000_0001;
                default: rb = $urandom;
            endcase
            refModel(rf, ra, rb, eh, el);
            applyStimulus(rf, ra, rb, $sformatf("rand%0d f=%02h a=%08h b=%08h", i, rf, ra, rb), eh, el);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
